// File: rtl/beamcon_loader_pkg.sv
// beamcon_loader_pkg
//   Shared definitions for the beam-counter register loader:
//   - bus widths of the custom-register write port
//   - video mode encoding (PAL15k / NTSC15k / VGA31k / reserved)
//   - custom register addresses (address bits [8:1]) HTOTAL..BEAMCON0
//   - loader FSM state encoding
//   - one 8-entry (addr, data) table per supported mode; BEAMCON0 is
//     always the last entry so the new timing only takes effect once
//     every counter limit is already in place.
package beamcon_loader_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    MODE_PAL  = 2'b00,
    MODE_NTSC = 2'b01,
    MODE_VGA  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  localparam logic [ADDR_W-1:0] REG_HTOTAL   = 8'hE0;
  localparam logic [ADDR_W-1:0] REG_HSSTOP   = 8'hE1;
  localparam logic [ADDR_W-1:0] REG_HBSTRT   = 8'hE2;
  localparam logic [ADDR_W-1:0] REG_HBSTOP   = 8'hE3;
  localparam logic [ADDR_W-1:0] REG_VTOTAL   = 8'hE4;
  localparam logic [ADDR_W-1:0] REG_VSSTOP   = 8'hE5;
  localparam logic [ADDR_W-1:0] REG_VBSTRT   = 8'hE6;
  localparam logic [ADDR_W-1:0] REG_BEAMCON0 = 8'hEE;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_EOF = 2'd1,
    ST_ISSUE    = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } beam_entry_t;

  localparam beam_entry_t PAL_TABLE [0:7] = '{
    '{REG_HTOTAL,   16'h00E3},
    '{REG_HSSTOP,   16'h0013},
    '{REG_HBSTRT,   16'h0001},
    '{REG_HBSTOP,   16'h0021},
    '{REG_VTOTAL,   16'h0270},
    '{REG_VSSTOP,   16'h0005},
    '{REG_VBSTRT,   16'h0000},
    '{REG_BEAMCON0, 16'h0020}
  };

  localparam beam_entry_t NTSC_TABLE [0:7] = '{
    '{REG_HTOTAL,   16'h00E2},
    '{REG_HSSTOP,   16'h0013},
    '{REG_HBSTRT,   16'h0001},
    '{REG_HBSTOP,   16'h0021},
    '{REG_VTOTAL,   16'h020C},
    '{REG_VSSTOP,   16'h0005},
    '{REG_VBSTRT,   16'h0000},
    '{REG_BEAMCON0, 16'h0000}
  };

  localparam beam_entry_t VGA_TABLE [0:7] = '{
    '{REG_HTOTAL,   16'h0071},
    '{REG_HSSTOP,   16'h0008},
    '{REG_HBSTRT,   16'h0001},
    '{REG_HBSTOP,   16'h0011},
    '{REG_VTOTAL,   16'h020D},
    '{REG_VSSTOP,   16'h0002},
    '{REG_VBSTRT,   16'h0000},
    '{REG_BEAMCON0, 16'h1B88}
  };

endpackage

// File: rtl/beamcon_table.sv
// beamcon_table
//   Purely combinational lookup of one loader entry.
//   Ports:
//     mode  in  2   latched video mode (reserved mode yields all-zero entry)
//     index in  3   entry number 0..7
//     addr  out 8   register address [8:1] of the entry
//     data  out 16  value to write
module beamcon_table
  import beamcon_loader_pkg::*;
(
  input  logic [1:0]        mode,
  input  logic [2:0]        index,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  beam_entry_t entry;

  always_comb begin
    entry = '0;
    case (mode)
      MODE_PAL:  entry = PAL_TABLE[index];
      MODE_NTSC: entry = NTSC_TABLE[index];
      MODE_VGA:  entry = VGA_TABLE[index];
      default:   entry = '0;
    endcase
  end

  assign addr = entry.addr;
  assign data = entry.data;

endmodule

// File: rtl/beamcon_loader.sv
// beamcon_loader
//   Loads the 8 beam-counter registers for a selected video mode through
//   the shared custom-register write port, interleaving with CPU writes.
//   The CPU always wins a clk7_en bus slot; the loader only uses slots the
//   CPU leaves free. All outputs are registered: a write granted on a
//   clk7_en cycle shows up on reg_wr/reg_address_out/data_out during the
//   following clk cycle, for exactly one cycle.
//
//   Optional feature (macro BEAMCON_LOADER_VBL_SYNC_EN):
//     defined   - after start the loader waits for eof before issuing, so
//                 the new timing lands at a frame boundary.
//     undefined - the loader issues straight after start; eof is ignored.
//
//   Ports:
//     clk             in   28 MHz bus clock
//     reset           in   synchronous, active-high
//     clk7_en         in   7 MHz bus slot qualifier
//     eof             in   end-of-frame pulse from the beam counter
//     start           in   one-cycle load request
//     mode            in   00 PAL15k, 01 NTSC15k, 10 VGA31k, 11 reserved
//     cpu_wr          in   CPU custom-register write request
//     cpu_addr        in   CPU register address [8:1]
//     cpu_data        in   CPU write data
//     reg_address_out out  shared register address [8:1] (0 when idle)
//     data_out        out  shared register write data (0 when idle)
//     reg_wr          out  write strobe
//     busy            out  load sequence in progress
//     done            out  one-cycle completion pulse
//     err             out  one-cycle pulse when start requests mode 11
module beamcon_loader
  import beamcon_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clk7_en,
  input  logic              eof,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic [ADDR_W-1:0] reg_address_out,
  output logic [DATA_W-1:0] data_out,
  output logic              reg_wr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state;
  logic [1:0]        mode_q;
  logic [2:0]        index;
  logic [ADDR_W-1:0] tbl_addr;
  logic [DATA_W-1:0] tbl_data;
  logic              slot_cpu;
  logic              slot_free;

  assign slot_cpu  = clk7_en & cpu_wr;
  assign slot_free = clk7_en & ~cpu_wr;

  beamcon_table u_table (
    .mode  (mode_q),
    .index (index),
    .addr  (tbl_addr),
    .data  (tbl_data)
  );

`ifndef BEAMCON_LOADER_VBL_SYNC_EN
  // Frame sync is compiled out, so the end-of-frame pulse has no consumer.
  logic unused_eof;
  assign unused_eof = eof;
`endif

  // Write port: CPU first, then a pending loader entry, else a quiet bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_wr          <= 1'b0;
      reg_address_out <= '0;
      data_out        <= '0;
    end else if (slot_cpu) begin
      reg_wr          <= 1'b1;
      reg_address_out <= cpu_addr;
      data_out        <= cpu_data;
    end else if (slot_free && (state == ST_ISSUE)) begin
      reg_wr          <= 1'b1;
      reg_address_out <= tbl_addr;
      data_out        <= tbl_data;
    end else begin
      reg_wr          <= 1'b0;
      reg_address_out <= '0;
      data_out        <= '0;
    end
  end

  // Sequencer: accepts a start only from IDLE, walks index 0..7 over the
  // free slots and never wraps; index 7 being written ends the sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      mode_q <= 2'b00;
      index  <= 3'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (mode == MODE_RSVD) begin
              err <= 1'b1;
            end else begin
              mode_q <= mode;
              index  <= 3'd0;
              busy   <= 1'b1;
`ifdef BEAMCON_LOADER_VBL_SYNC_EN
              state  <= ST_WAIT_EOF;
`else
              state  <= ST_ISSUE;
`endif
            end
          end
        end
        ST_WAIT_EOF: begin
`ifdef BEAMCON_LOADER_VBL_SYNC_EN
          // Only an eof seen after the start cycle gets here, so a
          // coincident start/eof pair does not trigger the load.
          if (eof) begin
            state <= ST_ISSUE;
          end
`else
          state <= ST_IDLE;
          busy  <= 1'b0;
`endif
        end
        ST_ISSUE: begin
          if (slot_free) begin
            if (index == 3'd7) begin
              state <= ST_DONE;
            end else begin
              index <= index + 3'd1;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beamcon_loader.sv
// tb_beamcon_loader
//   Directed scenarios plus randomized traffic for beamcon_loader. Every
//   cycle's inputs and outputs are recorded; a transaction-level reference
//   model then derives the expected outputs for each cycle and all of them
//   are compared, followed by scenario-specific checks.
module tb_beamcon_loader;

  localparam int MAXC = 1200;

  localparam logic [7:0] TADDR [0:7] = '{8'hE0, 8'hE1, 8'hE2, 8'hE3,
                                         8'hE4, 8'hE5, 8'hE6, 8'hEE};
  localparam logic [15:0] TDATA [0:2][0:7] = '{
    '{16'h00E3, 16'h0013, 16'h0001, 16'h0021, 16'h0270, 16'h0005, 16'h0000, 16'h0020},
    '{16'h00E2, 16'h0013, 16'h0001, 16'h0021, 16'h020C, 16'h0005, 16'h0000, 16'h0000},
    '{16'h0071, 16'h0008, 16'h0001, 16'h0011, 16'h020D, 16'h0002, 16'h0000, 16'h1B88}};

`ifdef BEAMCON_LOADER_VBL_SYNC_EN
  localparam bit VBL = 1'b1;
`else
  localparam bit VBL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, clk7_en, eof, start, cpu_wr;
  logic [1:0]  mode;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_data;
  logic [7:0]  reg_address_out;
  logic [15:0] data_out;
  logic        reg_wr, busy, done, err;

  always #18 clk = ~clk;

  beamcon_loader dut (
    .clk             (clk),
    .reset           (reset),
    .clk7_en         (clk7_en),
    .eof             (eof),
    .start           (start),
    .mode            (mode),
    .cpu_wr          (cpu_wr),
    .cpu_addr        (cpu_addr),
    .cpu_data        (cpu_data),
    .reg_address_out (reg_address_out),
    .data_out        (data_out),
    .reg_wr          (reg_wr),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;
  int phase = 0;

  // recorded inputs / observed outputs / expected outputs, per cycle
  bit          i_rst [MAXC], i_st [MAXC], i_ef [MAXC], i_ce [MAXC], i_cw [MAXC];
  logic [1:0]  i_md  [MAXC];
  logic [7:0]  i_ca  [MAXC];
  logic [15:0] i_cd  [MAXC];
  logic        o_wr  [MAXC], o_bz [MAXC], o_dn [MAXC], o_er [MAXC];
  logic [7:0]  o_ad  [MAXC];
  logic [15:0] o_dt  [MAXC];
  logic        e_wr  [MAXC], e_bz [MAXC], e_dn [MAXC], e_er [MAXC];
  logic [7:0]  e_ad  [MAXC];
  logic [15:0] e_dt  [MAXC];

  // observed write list and events of the last checked scenario
  int          w_cyc [$];
  logic [7:0]  w_ad  [$];
  logic [15:0] w_dt  [$];
  int          dn_cyc [$];
  int          n_errp;
  int          n_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit slot_at(input int c);
    return ((c + phase) % 4) == 0;
  endfunction

  function automatic int nth_slot(input int from, input int n);
    int seen = 0;
    for (int c = from; c < from + 64; c++) begin
      if (slot_at(c)) begin
        seen++;
        if (seen == n) return c;
      end
    end
    return -1;
  endfunction

  // One bus cycle: drive the slot qualifier, record inputs, sample outputs
  // mid-cycle, advance past the edge, then drop the one-cycle pulses.
  task automatic tick();
    if (cyc >= MAXC - 1) begin
      n_err++;
      $display("FAIL cycle_budget observed=%0d required<%0d", cyc, MAXC - 1);
      $fatal(1, "cycle budget exhausted");
    end
    clk7_en   = slot_at(cyc);
    i_rst[cyc] = reset;  i_st[cyc] = start;  i_ef[cyc] = eof;
    i_ce[cyc]  = clk7_en; i_cw[cyc] = cpu_wr; i_md[cyc] = mode;
    i_ca[cyc]  = cpu_addr; i_cd[cyc] = cpu_data;
    @(negedge clk);
    o_wr[cyc] = reg_wr; o_ad[cyc] = reg_address_out; o_dt[cyc] = data_out;
    o_bz[cyc] = busy;   o_dn[cyc] = done;            o_er[cyc] = err;
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    eof   = 1'b0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic begin_scn(input int ph);
    cyc = 0;
    phase = ph;
    reset = 1'b1; start = 1'b0; eof = 1'b0; mode = 2'b00;
    cpu_wr = 1'b0; cpu_addr = 8'h00; cpu_data = 16'h0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Bring the loader into its issuing phase: with frame sync, pulse eof d
  // cycles after the accepted start; returns the first cycle whose slot
  // may carry a loader write.
  task automatic arm(input int s, input int d, output int act);
`ifdef BEAMCON_LOADER_VBL_SYNC_EN
    run_to(s + d);
    eof = 1'b1;
    tick();
    act = s + d + 1;
`else
    act = s + 1;
`endif
  endtask

  // Reference model: a start from idle opens a transaction that owns the
  // next 8 free slots once armed (by eof with frame sync, immediately
  // otherwise). Each write appears the cycle after its slot; done follows
  // the cycle after the last write; reset abandons everything.
  task automatic check_scn(input string name);
    bit loading = 0, armed = 0, idle0, full0;
    int k = 0, lm = 0;
    for (int c = 0; c < cyc - 1; c++) begin
      e_wr[c+1] = 1'b0; e_ad[c+1] = 8'h00; e_dt[c+1] = 16'h0000;
      e_bz[c+1] = 1'b0; e_dn[c+1] = 1'b0;  e_er[c+1] = 1'b0;
      if (i_rst[c]) begin
        loading = 0; armed = 0; k = 0;
        continue;
      end
      idle0 = !loading;
      full0 = loading && (k == 8);
      if (i_ce[c] && i_cw[c]) begin
        e_wr[c+1] = 1'b1; e_ad[c+1] = i_ca[c]; e_dt[c+1] = i_cd[c];
      end else if (i_ce[c] && loading && armed && k < 8) begin
        e_wr[c+1] = 1'b1; e_ad[c+1] = TADDR[k]; e_dt[c+1] = TDATA[lm][k];
        k++;
      end
      if (full0) begin
        e_dn[c+1] = 1'b1;
        loading = 0;
      end
      if (idle0) begin
        if (i_st[c]) begin
          if (i_md[c] == 2'b11) begin
            e_er[c+1] = 1'b1;
          end else begin
            loading = 1; armed = !VBL; k = 0; lm = int'(i_md[c]);
          end
        end
      end else if (VBL && !armed && i_ef[c]) begin
        armed = 1;
      end
      e_bz[c+1] = loading;
    end
    w_cyc.delete(); w_ad.delete(); w_dt.delete(); dn_cyc.delete();
    n_errp = 0; n_busy = 0;
    for (int c = 1; c < cyc; c++) begin
      chk($sformatf("%s.reg_wr@%0d", name, c), o_wr[c], e_wr[c]);
      chk($sformatf("%s.addr@%0d", name, c), o_ad[c], e_ad[c]);
      chk($sformatf("%s.data@%0d", name, c), o_dt[c], e_dt[c]);
      chk($sformatf("%s.busy@%0d", name, c), o_bz[c], e_bz[c]);
      chk($sformatf("%s.done@%0d", name, c), o_dn[c], e_dn[c]);
      chk($sformatf("%s.err@%0d", name, c), o_er[c], e_er[c]);
      if (o_wr[c] === 1'b1) begin
        w_cyc.push_back(c); w_ad.push_back(o_ad[c]); w_dt.push_back(o_dt[c]);
      end
      if (o_dn[c] === 1'b1) dn_cyc.push_back(c);
      if (o_er[c] === 1'b1) n_errp++;
      if (o_bz[c] === 1'b1) n_busy++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s2, act, slot3, slot5, r, first;
    reset = 1'b1; start = 1'b0; eof = 1'b0; mode = 2'b00; clk7_en = 1'b0;
    cpu_wr = 1'b0; cpu_addr = 8'h00; cpu_data = 16'h0000;
    @(posedge clk);
    #1;

    // S1: VGA load, eof 100 cycles after start, quiet CPU
    begin_scn(0);
    mode = 2'b10; start = 1'b1; s = cyc; tick();
    arm(s, 100, act);
    run_to(s + 160);
    check_scn("s1");
    chk("s1.reset_busy", o_bz[1], 1'b0);
    chk("s1.reset_wr", o_wr[1], 1'b0);
    chk("s1.count", w_cyc.size(), 8);
    if (w_cyc.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("s1.order%0d", i), w_ad[i], TADDR[i]);
        chk($sformatf("s1.on_slot%0d", i), i_ce[w_cyc[i] - 1], 1'b1);
      end
      chk("s1.first_latency", w_cyc[0], nth_slot(act, 1) + 1);
      chk("s1.done_count", dn_cyc.size(), 1);
      if (dn_cyc.size() == 1) chk("s1.done_after_ee", dn_cyc[0], w_cyc[7] + 1);
    end

    // S2: CPU write held across the 3rd loader slot
    begin_scn(1);
    mode = 2'b10; start = 1'b1; s = cyc; tick();
    arm(s, 7, act);
    slot3 = nth_slot(act, 3);
    run_to(slot3 - 1);
    cpu_wr = 1'b1; cpu_addr = 8'h80; cpu_data = 16'h1234;
    run_to(slot3 + 2);
    cpu_wr = 1'b0;
    run_to(slot3 + 60);
    check_scn("s2");
    chk("s2.count", w_cyc.size(), 9);
    if (w_cyc.size() == 9) begin
      chk("s2.cpu_cycle", w_cyc[2], slot3 + 1);
      chk("s2.cpu_addr", w_ad[2], 8'h80);
      chk("s2.cpu_data", w_dt[2], 16'h1234);
      chk("s2.deferred", w_ad[3], 8'hE2);
      chk("s2.last", w_ad[8], 8'hEE);
    end

    // S3: reserved mode
    begin_scn(2);
    mode = 2'b11; start = 1'b1; tick();
    run_to(40);
    check_scn("s3");
    chk("s3.err_pulses", n_errp, 1);
    chk("s3.busy_cycles", n_busy, 0);
    chk("s3.writes", w_cyc.size(), 0);

    // S4: reset on the 5th loader slot (with start/cpu_wr competing), reload
    begin_scn(3);
    mode = 2'b10; start = 1'b1; s = cyc; tick();
    arm(s, 5, act);
    slot5 = nth_slot(act, 5);
    run_to(slot5);
    r = cyc;
    reset = 1'b1; start = 1'b1; mode = 2'b00;
    cpu_wr = 1'b1; cpu_addr = 8'h55; cpu_data = 16'hBEEF;
    tick();
    reset = 1'b0; cpu_wr = 1'b0;
    run_to(r + 6);
    mode = 2'b01; start = 1'b1; s2 = cyc; tick();
    arm(s2, 9, act);
    run_to(act + 60);
    check_scn("s4");
    chk("s4.busy_after_reset", o_bz[r + 1], 1'b0);
    chk("s4.wr_after_reset", o_wr[r + 1], 1'b0);
    chk("s4.count", w_cyc.size(), 12);
    if (w_cyc.size() == 12) begin
      chk("s4.before_reset", w_ad[3], 8'hE3);
      chk("s4.reload_addr", w_ad[4], 8'hE0);
      chk("s4.reload_data", w_dt[4], 16'h00E2);
      chk("s4.reload_after", w_cyc[4] > s2, 1'b1);
    end

    // S5: second start and mode change while busy
    begin_scn(0);
    mode = 2'b10; start = 1'b1; s = cyc; tick();
    arm(s, 12, act);
    run_to(nth_slot(act, 2) + 1);
    mode = 2'b00; start = 1'b1; eof = 1'b1;
    tick();
    run_to(act + 70);
    check_scn("s5");
    chk("s5.count", w_cyc.size(), 8);
    if (w_cyc.size() == 8) begin
      for (int i = 0; i < 8; i++) chk($sformatf("s5.vga_data%0d", i), w_dt[i], TDATA[2][i]);
      chk("s5.beamcon0", w_dt[7], 16'h1B88);
    end

    // S6: start without eof (frame sync: coincident eof must not count)
    begin_scn(2);
`ifdef BEAMCON_LOADER_VBL_SYNC_EN
    mode = 2'b00; start = 1'b1; eof = 1'b1; s = cyc; tick();
    run_to(s + 30);
    eof = 1'b1; tick();
    act = s + 31;
    run_to(act + 50);
    check_scn("s6");
    chk("s6.waiting_busy", o_bz[s + 20], 1'b1);
    first = nth_slot(act, 1) + 1;
`else
    mode = 2'b00; start = 1'b1; s = cyc; tick();
    run_to(s + 50);
    check_scn("s6");
    first = nth_slot(s + 1, 1) + 1;
`endif
    chk("s6.count", w_cyc.size(), 8);
    if (w_cyc.size() == 8) begin
      chk("s6.first_cycle", w_cyc[0], first);
      chk("s6.first_addr", w_ad[0], 8'hE0);
      chk("s6.first_data", w_dt[0], 16'h00E3);
    end

    // Randomized traffic: starts, modes, eofs, CPU writes, occasional reset
    for (int run = 0; run < 2; run++) begin
      begin_scn(int'($urandom_range(3)));
      for (int i = 0; i < 350; i++) begin
        reset    = ($urandom_range(99) == 0);
        start    = ($urandom_range(19) == 0);
        mode     = 2'($urandom_range(3));
        eof      = ($urandom_range(29) == 0);
        cpu_wr   = ($urandom_range(3) == 0);
        cpu_addr = 8'($urandom);
        cpu_data = 16'($urandom);
        tick();
      end
      reset = 1'b0; cpu_wr = 1'b0;
      run_to(cyc + 60);
      check_scn($sformatf("rand%0d", run));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
